// File: rtl/spc_pkg.sv
// Shared definitions for the serial parity checker and its building blocks.
// Contents: FSM state type, default payload width, bit-counter width helper,
// width of the optional parity-error counter.
// Optional feature macro used by the top: SPC_ERR_COUNT_EN.
package spc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StDone
    } spc_state_e;

    localparam int unsigned DEFAULT_DATA_BITS = 8;
    localparam int unsigned ERR_COUNT_W       = 8;

    // The counter must represent 0..DATA_BITS.
    function automatic int unsigned cnt_width(input int unsigned data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/parity_accum.sv
// 1-bit registered running XOR with synchronous clear and enable.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the accumulator
//   clr    - clear the accumulator on the next edge (wins over en)
//   en     - XOR bit_in into the accumulator on the next edge
//   bit_in - serial bit
//   acc    - current accumulated XOR
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises a framed LSB-first bit stream of DATA_BITS payload bits plus a
// trailing parity bit, and presents the captured word with a parity-error flag.
// Parameters:
//   DATA_BITS  - payload bits per frame (2..32)
//   PARITY_ODD - 0: even parity, 1: odd parity
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   start       - frame start strobe, honoured only when idle
//   bit_in      - serial data/parity bit
//   bit_valid   - bit_in valid this cycle; low stalls the frame
//   abort       - drop the frame in progress
//   data_out    - last completed payload
//   data_valid  - one-cycle pulse when data_out/parity_err update
//   parity_err  - parity mismatch for the frame in data_out
//   busy        - frame in progress (DATA, PARITY, DONE)
//   err_count   - saturating count of parity errors (only with SPC_ERR_COUNT_EN)
// Optional feature macro: SPC_ERR_COUNT_EN.
module serial_parity_checker
    import spc_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   abort,
    output logic [DATA_BITS-1:0]   data_out,
    output logic                   data_valid,
    output logic                   parity_err,
    output logic                   busy
`ifdef SPC_ERR_COUNT_EN
    ,
    output logic [ERR_COUNT_W-1:0] err_count
`endif
);

    localparam int unsigned CNT_W = cnt_width(DATA_BITS);

    spc_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 acc;
    logic                 acc_clr;
    logic                 acc_en;

    parity_accum u_parity_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (bit_in),
        .acc    (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        perr_d  = perr_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StData;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            StData: begin
                // abort wins over a coincident valid bit
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_valid) begin
                    // Shifting in at the MSB lands bit k at index k once all
                    // DATA_BITS bits have arrived.
                    shift_d = {bit_in, shift_q[DATA_BITS-1:1]};
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_valid) begin
                    data_d  = shift_q;
                    perr_d  = ((acc ^ bit_in) != PARITY_ODD);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign data_valid = (state_q == StDone);
    assign busy       = (state_q != StIdle);

`ifdef SPC_ERR_COUNT_EN
    logic [ERR_COUNT_W-1:0] err_cnt_q;

    // parity_err already holds this frame's result while in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (state_q == StDone && perr_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_COUNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
